inst_fetch_queue: RTL
=====================

Name: inst_fetch_queue

Overview:
- Instruction-fetch stage that sits directly upstream of the decode stage.
- Keeps the fetch PC and issues word reads to instruction memory, one outstanding read at a time.
- Buffers returned words with their PCs in a small FIFO and presents the head to decode (IF_Instruction feeds decode's InstMem_In path).
- Supports decode back-pressure (stall) and branch/exception redirect (flush).

Parameters:
RESET_PC, 32'hBFC0_0000, fetch PC loaded on reset (MIPS reset vector).
DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst_n  in  1  synchronous, active-low reset.
InstMem_Address  out  30  word address = fetch PC[31:2].
InstMem_Read  out  1  read request; held with stable address until InstMem_Ready sampled high.
InstMem_Ready  in  1  read data valid this cycle for the outstanding request.
InstMem_In  in  32  read data.
Redirect  in  1  flush and restart fetch at Redirect_PC.
Redirect_PC  in  32  new PC; bits [1:0] ignored (forced 0).
ID_Stall  in  1  decode cannot accept the head this cycle.
IF_Valid  out  1  FIFO non-empty; head presented.
IF_Instruction  out  32  head instruction word.
IF_PC  out  32  PC of head instruction.
Count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0 at edge, overrides everything): PC=RESET_PC, FIFO cleared, Count=0, IF_Valid=0, IF_Instruction=0, IF_PC=0, InstMem_Read=0, state IDLE.
- FSM states:
  - IDLE: no request. Go to REQ when Count_next < DEPTH.
  - REQ: InstMem_Read=1, address=PC[31:2].
  - DRAIN: InstMem_Read=1 for a request whose data must be discarded.
- Issue guard: a request starts only if Count_next < DEPTH. With a single outstanding request, the returned word therefore always fits; no overflow path exists.
- Push: REQ and InstMem_Ready and no Redirect. Writes {PC, InstMem_In} at tail and sets PC += 4, wrapping modulo 2^32.
- After a push, stay in REQ (back-to-back, 1 word/cycle with a zero-wait memory) if Count_next < DEPTH; otherwise go to IDLE.
- Pop: IF_Valid && !ID_Stall && !Redirect at edge; head advances.
- IF_Valid, IF_Instruction and IF_PC reflect the head entry from registered storage. IF_Instruction/IF_PC hold their value while stalled.
- Latency: data sampled with Ready at edge N is visible (IF_Valid=1) after edge N.
- Simultaneous push and pop: Count unchanged, order preserved. Push into an empty FIFO with no pop: IF_Valid rises after that edge.
- Redirect has highest priority and takes effect the same cycle:
  - FIFO cleared (Count=0, IF_Valid=0 after edge); any concurrent pop is cancelled.
  - PC := {Redirect_PC[31:2],2'b00}.
  - IDLE → REQ.
  - REQ with Ready this cycle → data discarded, REQ at the new PC.
  - REQ without Ready → DRAIN (Read stays high, old address held).
  - DRAIN → PC updated, stay in DRAIN.
- DRAIN + InstMem_Ready → data discarded, go to REQ at the current PC.
- InstMem_Ready while IDLE, or after reset, is ignored.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is saturation-free by construction; the bench asserts Count <= DEPTH.

Test Plan:
1. Release reset, memory returns Ready=1 the cycle Read is seen, ID_Stall=0 → first InstMem_Address=30'h2FF0_0000; IF_PC sequence 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles with no gaps.
2. ID_Stall=1 for 12 cycles, DEPTH=4 → Count reaches 4, InstMem_Read drops, IF_PC holds 0xBFC00000. Release → PCs emerge in order with no loss or duplication.
3. Memory with 3-cycle latency; Redirect_PC=0x80001002 one cycle after Read rises → state DRAIN, returned word discarded, IF_Valid stays 0. Next address 30'h2000_0400; first IF_PC=0x80001000.
4. Redirect in the same cycle as InstMem_Ready and a pop, with Count=2 → next cycle Count=0, IF_Valid=0; neither the popped nor the returned word ever appears again.
5. rst_n=0 mid-request with Count=2 → after the edge IF_Valid=0, InstMem_Read=0, Count=0, PC=RESET_PC. A stray Ready in the following cycle causes no push.
6. Redirect to 0xFFFFFFFC → fetch addresses 30'h3FFF_FFFF then 30'h0000_0000; IF_PC 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue_if
//
// Purpose: bundles the instruction-memory read port, the redirect/stall
// controls and the decode-facing head-of-queue outputs of inst_fetch_queue.
//
// Signals:
//   InstMem_Address  word address of the outstanding read (fetch PC[31:2])
//   InstMem_Read     read request, held with a stable address until Ready
//   InstMem_Ready    read data valid this cycle for the outstanding request
//   InstMem_In       read data
//   Redirect         flush the queue and restart fetch at Redirect_PC
//   Redirect_PC      restart PC, bits [1:0] ignored
//   ID_Stall         decode cannot accept the head this cycle
//   IF_Valid         queue non-empty, head presented
//   IF_Instruction   head instruction word
//   IF_PC            PC of the head instruction
//   Count            queue occupancy
//
// Modports:
//   master  the fetch queue itself
//   slave   the surrounding memory / decode / control environment
// ---------------------------------------------------------------------------
interface inst_fetch_queue_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic [29:0]   InstMem_Address;
    logic          InstMem_Read;
    logic          InstMem_Ready;
    logic [31:0]   InstMem_In;
    logic          Redirect;
    logic [31:0]   Redirect_PC;
    logic          ID_Stall;
    logic          IF_Valid;
    logic [31:0]   IF_Instruction;
    logic [31:0]   IF_PC;
    logic [CW-1:0] Count;

    modport master (
        output InstMem_Address,
        output InstMem_Read,
        input  InstMem_Ready,
        input  InstMem_In,
        input  Redirect,
        input  Redirect_PC,
        input  ID_Stall,
        output IF_Valid,
        output IF_Instruction,
        output IF_PC,
        output Count
    );

    modport slave (
        input  InstMem_Address,
        input  InstMem_Read,
        output InstMem_Ready,
        output InstMem_In,
        output Redirect,
        output Redirect_PC,
        output ID_Stall,
        input  IF_Valid,
        input  IF_Instruction,
        input  IF_PC,
        input  Count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
//
// Purpose: instruction-fetch stage ahead of decode. Holds the fetch PC,
// issues one outstanding word read at a time to instruction memory, buffers
// returned words with their PCs in a DEPTH-entry FIFO and presents the head
// to decode. Supports decode back-pressure (ID_Stall) and redirect/flush.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   bus          inst_fetch_queue_if.master (memory port, controls, head)
//   dbg_state_o  fetch FSM state: 0 = IDLE, 1 = REQ, 2 = DRAIN
//
// Handshakes:
//   Memory: a request is open while InstMem_Read is high; address is held
//   stable until a cycle in which InstMem_Ready is sampled high, which
//   completes that request (at most one request is ever open).
//   Decode: the head is transferred on an edge where IF_Valid is high,
//   ID_Stall is low and Redirect is low; otherwise the head holds.
// ---------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    inst_fetch_queue_if.master        bus,
    output logic [1:0]                dbg_state_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [29:0]   drain_addr_q, drain_addr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   mem_pc_q   [DEPTH];
    logic [31:0]   mem_inst_q [DEPTH];

    logic          valid;
    logic          push;
    logic          pop;
    logic          has_room;
    logic          unused_pc_lsbs;

    // The low two bits of the redirect target are forced to zero.
    assign unused_pc_lsbs = ^bus.Redirect_PC[1:0];

    // -----------------------------------------------------------------------
    // FIFO bookkeeping
    // -----------------------------------------------------------------------
    always_comb begin
        valid    = (count_q != '0);
        push     = (state_q == ST_REQ) && bus.InstMem_Ready && !bus.Redirect;
        pop      = valid && !bus.ID_Stall && !bus.Redirect;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.Redirect) begin
            // Flush wins over any concurrent push or pop.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        // A new request may only open if its word is guaranteed a slot.
        has_room = (count_d < DEPTH_C);
    end

    // -----------------------------------------------------------------------
    // Fetch FSM and PC
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;

        if (bus.Redirect) begin
            pc_d = {bus.Redirect_PC[31:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end

        case (state_q)
            ST_IDLE: begin
                if (has_room) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.Redirect && !bus.InstMem_Ready) begin
                    // The open request cannot be withdrawn: keep its address
                    // on the bus and throw its data away when it arrives.
                    state_d      = ST_DRAIN;
                    drain_addr_d = pc_q[31:2];
                end else if (bus.InstMem_Ready && !bus.Redirect && !has_room) begin
                    state_d = ST_IDLE;
                end
                // Redirect with Ready: data dropped, new request at new PC.
            end
            ST_DRAIN: begin
                if (bus.InstMem_Ready) begin
                    state_d = has_room ? ST_REQ : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: an entry is only visible once written.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_pc_q[wr_ptr_q]   <= pc_q;
            mem_inst_q[wr_ptr_q] <= bus.InstMem_In;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.InstMem_Read    = (state_q != ST_IDLE);
    assign bus.InstMem_Address = (state_q == ST_DRAIN) ? drain_addr_q : pc_q[31:2];
    assign bus.IF_Valid        = valid;
    // Head is gated to zero while empty so stale entries never leak out.
    assign bus.IF_Instruction  = valid ? mem_inst_q[rd_ptr_q] : 32'd0;
    assign bus.IF_PC           = valid ? mem_pc_q[rd_ptr_q]   : 32'd0;
    assign bus.Count           = count_q;
    assign dbg_state_o         = state_q;

endmodule
